// File: rtl/pal_mc_fabric_pkg.sv
// Shared types and configuration-layout helpers for the PAL macrocell fabric.
// All bit offsets index the active configuration vector.
package pal_mc_fabric_pkg;

  typedef enum logic [1:0] {
    MC_COMB = 2'b00,
    MC_D    = 2'b01,
    MC_T    = 2'b10,
    MC_INV  = 2'b11
  } mc_mode_e;

  function automatic int unsigned cfg_len(input int unsigned n, input int unsigned m,
                                          input int unsigned p, input int unsigned fb);
    return 2 * (n + fb * m) * p + m * p + 2 * m;
  endfunction

  // True literal of column j in term p; the complement sits at the next bit.
  function automatic int unsigned and_bit(input int unsigned k, input int unsigned p,
                                          input int unsigned j);
    return p * 2 * k + 2 * j;
  endfunction

  function automatic int unsigned or_bit(input int unsigned k, input int unsigned pn,
                                         input int unsigned m, input int unsigned p);
    return 2 * k * pn + m * pn + p;
  endfunction

  function automatic int unsigned mode_bit(input int unsigned k, input int unsigned pn,
                                           input int unsigned mn, input int unsigned m);
    return 2 * k * pn + mn * pn + 2 * m;
  endfunction

endpackage

// File: rtl/pal_mc_fabric_if.sv
// Fabric bus: enable, serial config chain and the input/output vectors.
interface pal_mc_fabric_if #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 6
);
  logic         en;
  logic         cfg_in;
  logic         cfg_shift;
  logic         cfg_commit;
  logic         cfg_out;
  logic         cfg_loaded;
  logic         cfg_err;
  logic [N-1:0] in_vars;
  logic [M-1:0] out_vals;

  modport master (
    output en, cfg_in, cfg_shift, cfg_commit, in_vars,
    input  cfg_out, cfg_loaded, cfg_err, out_vals
  );

  modport slave (
    input  en, cfg_in, cfg_shift, cfg_commit, in_vars,
    output cfg_out, cfg_loaded, cfg_err, out_vals
  );
endinterface

// File: rtl/pal_mc_fabric_macrocell.sv
// One output macrocell: mode decode, q register (D or toggle), gated output mux.
module pal_mc_fabric_macrocell
  import pal_mc_fabric_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     i_en,
  input  logic     i_clr,
  input  mc_mode_e i_mode,
  input  logic     i_s,
  output logic     o_out,
  output logic     o_q
);
  logic r_q;
  logic w_d;

  always_comb begin
    w_d   = (i_mode == MC_T) ? (r_q ^ i_s) : i_s;
    o_out = 1'b0;
    if (i_en) begin
      case (i_mode)
        MC_COMB: o_out = i_s;
        MC_INV:  o_out = ~i_s;
        default: o_out = r_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= 1'b0;
    end else if (i_clr) begin
      r_q <= 1'b0;
    end else if (i_en) begin
      r_q <= w_d;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/pal_mc_fabric.sv
// PAL fabric with output macrocells and registered feedback. Config is shifted into a
// shadow chain and copied to the active image only on a commit after a full-length load.
module pal_mc_fabric
  import pal_mc_fabric_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned M  = 6,
  parameter int unsigned P  = 19,
  parameter int unsigned FB = 1
) (
  input  logic              clk,
  input  logic              res,
  pal_mc_fabric_if.slave    bus
);
  localparam int unsigned K       = N + FB * M;
  localparam int unsigned CFG_LEN = cfg_len(N, M, P, FB);
  localparam int unsigned CW      = $clog2(CFG_LEN + 1);

  logic [CFG_LEN-1:0] r_shadow;
  logic [CFG_LEN-1:0] r_active;
  logic [CW-1:0]      r_count;
  logic               r_loaded;
  logic               r_err;

  logic               w_commit_ok;
  logic               w_mc_en;
  logic [K-1:0]       w_cols;
  logic [P-1:0]       w_terms;
  logic [M-1:0]       w_s;
  logic [M-1:0]       w_q;
  logic [M-1:0]       w_out;

  // A commit coinciding with a shift is refused even if the count is already full.
  assign w_commit_ok = bus.cfg_commit && !bus.cfg_shift && (r_count == CW'(CFG_LEN));
  assign w_mc_en     = bus.en && r_loaded;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_shadow <= '0;
      r_active <= '0;
      r_count  <= '0;
      r_loaded <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (bus.cfg_shift) begin
        r_shadow <= {bus.cfg_in, r_shadow[CFG_LEN-1:1]};
        if (r_count != CW'(CFG_LEN)) begin
          r_count <= r_count + CW'(1);
        end
      end
      if (bus.cfg_commit) begin
        if (w_commit_ok) begin
          r_active <= r_shadow;
          r_count  <= '0;
          r_loaded <= 1'b1;
          r_err    <= 1'b0;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  generate
    if (FB != 0) begin : g_fb
      assign w_cols = {w_q, bus.in_vars};
    end else begin : g_nofb
      assign w_cols = bus.in_vars;
    end
  endgenerate

  for (genvar p = 0; p < P; p++) begin : g_and
    logic [K-1:0] w_t;
    logic [K-1:0] w_c;
    for (genvar j = 0; j < K; j++) begin : g_lit
      assign w_t[j] = r_active[and_bit(K, p, j)];
      assign w_c[j] = r_active[and_bit(K, p, j) + 1];
    end
    // Both polarities on one column can never be satisfied, so that case needs no special term.
    assign w_terms[p] = (|(w_t | w_c)) && ((w_t & ~w_cols) == '0) && ((w_c & w_cols) == '0);
  end

  for (genvar m = 0; m < M; m++) begin : g_or
    assign w_s[m] = |(w_terms & r_active[or_bit(K, P, m, 0) +: P]);

    pal_mc_fabric_macrocell u_mc (
      .clk    (clk),
      .rst    (res),
      .i_en   (w_mc_en),
      .i_clr  (w_commit_ok),
      .i_mode (mc_mode_e'(r_active[mode_bit(K, P, M, m) +: 2])),
      .i_s    (w_s[m]),
      .o_out  (w_out[m]),
      .o_q    (w_q[m])
    );
  end

  assign bus.out_vals   = w_out;
  assign bus.cfg_out    = r_shadow[0];
  assign bus.cfg_loaded = r_loaded;
  assign bus.cfg_err    = r_err;
endmodule

// File: tb/tb_pal_mc_fabric.sv
// Directed self-checking bench for pal_mc_fabric at default parameters (CFG_LEN = 658).
module tb_pal_mc_fabric;
  localparam int unsigned CL = 658;

  logic clk = 1'b0;
  logic res = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [CL-1:0] cfg_a, cfg_b, cfg_c, cfg_d;

  pal_mc_fabric_if #(.N(8), .M(6)) bus ();

  pal_mc_fabric #(.N(8), .M(6), .P(19), .FB(1)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic shift_bits(input logic [CL-1:0] v, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      bus.cfg_shift = 1'b1;
      bus.cfg_in    = v[i];
    end
    @(negedge clk);
    bus.cfg_shift = 1'b0;
    bus.cfg_in    = 1'b0;
  endtask

  task automatic commit_pulse();
    @(negedge clk);
    bus.cfg_commit = 1'b1;
    @(negedge clk);
    bus.cfg_commit = 1'b0;
  endtask

  task automatic load(input logic [CL-1:0] v);
    shift_bits(v, CL);
    commit_pulse();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      bus.cfg_shift = 1'b1;
      bus.cfg_in    = 1'b1;
    end
    @(negedge clk);
    bus.cfg_shift  = 1'b0;
    bus.cfg_commit = 1'b1;
    @(negedge clk);
    bus.cfg_commit = 1'b0;
    checks++;
    if (bus.cfg_err !== 1'b1) begin errors++; $display("FAIL pre_reset_err got=%b exp=1", bus.cfg_err); end
    bus.cfg_shift = 1'b1;
    #2 res = 1'b1;
    #1;
    checks++;
    if (bus.out_vals !== 6'h00) begin errors++; $display("FAIL rst_out got=%h exp=00", bus.out_vals); end
    checks++;
    if (bus.cfg_loaded !== 1'b0) begin errors++; $display("FAIL rst_loaded got=%b exp=0", bus.cfg_loaded); end
    checks++;
    if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", bus.cfg_err); end
    checks++;
    if (bus.cfg_out !== 1'b0) begin errors++; $display("FAIL rst_cfg_out got=%b exp=0", bus.cfg_out); end
    @(negedge clk);
    res = 1'b0;
    bus.cfg_shift = 1'b0;
    shift_bits(cfg_a, CL - 1);
    commit_pulse();
    checks++;
    if (bus.cfg_err !== 1'b1 || bus.cfg_loaded !== 1'b0) begin
      errors++; $display("FAIL rst_count_restart got err=%b loaded=%b exp err=1 loaded=0", bus.cfg_err, bus.cfg_loaded);
    end
  endtask

  task automatic test_comb();
    load(cfg_a);
    checks++;
    if (bus.cfg_loaded !== 1'b1 || bus.cfg_err !== 1'b0) begin
      errors++; $display("FAIL comb_load got loaded=%b err=%b exp loaded=1 err=0", bus.cfg_loaded, bus.cfg_err);
    end
    bus.in_vars = 8'h01; #1;
    checks++;
    if (bus.out_vals !== 6'h01) begin errors++; $display("FAIL comb_in01 got=%h exp=01", bus.out_vals); end
    bus.in_vars = 8'h03; #1;
    checks++;
    if (bus.out_vals !== 6'h00) begin errors++; $display("FAIL comb_in03 got=%h exp=00", bus.out_vals); end
    bus.in_vars = 8'h00; #1;
    checks++;
    if (bus.out_vals !== 6'h00) begin errors++; $display("FAIL comb_in00 got=%h exp=00", bus.out_vals); end
    load(cfg_b);
    bus.in_vars = 8'h01; #1;
    checks++;
    if (bus.out_vals !== 6'h00) begin errors++; $display("FAIL inv_in01 got=%h exp=00", bus.out_vals); end
    bus.in_vars = 8'h03; #1;
    checks++;
    if (bus.out_vals !== 6'h01) begin errors++; $display("FAIL inv_in03 got=%h exp=01", bus.out_vals); end
  endtask

  task automatic test_short_load();
    shift_bits(cfg_a, CL - 1);
    commit_pulse();
    #1;
    checks++;
    if (bus.cfg_err !== 1'b1 || bus.cfg_loaded !== 1'b1) begin
      errors++; $display("FAIL short_err got err=%b loaded=%b exp err=1 loaded=1", bus.cfg_err, bus.cfg_loaded);
    end
    checks++;
    if (bus.out_vals !== 6'h01) begin errors++; $display("FAIL short_keep got=%h exp=01", bus.out_vals); end
    @(negedge clk);
    bus.cfg_shift  = 1'b1;
    bus.cfg_in     = cfg_a[CL-1];
    bus.cfg_commit = 1'b1;
    @(negedge clk);
    bus.cfg_shift  = 1'b0;
    bus.cfg_in     = 1'b0;
    bus.cfg_commit = 1'b0;
    #1;
    checks++;
    if (bus.cfg_err !== 1'b1 || bus.out_vals !== 6'h01) begin
      errors++; $display("FAIL shift_commit got err=%b out=%h exp err=1 out=01", bus.cfg_err, bus.out_vals);
    end
    commit_pulse();
    #1;
    checks++;
    if (bus.cfg_err !== 1'b0 || bus.out_vals !== 6'h00) begin
      errors++; $display("FAIL full_after_shift_commit got err=%b out=%h exp err=0 out=00", bus.cfg_err, bus.out_vals);
    end
  endtask

  task automatic test_counter();
    logic [1:0] exp_seq [4];
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0};
    bus.in_vars = 8'h00;
    load(cfg_c);
    bus.in_vars = 8'h80; #1;
    checks++;
    if (bus.out_vals !== 6'h00) begin errors++; $display("FAIL cnt_start got=%h exp=00", bus.out_vals); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.out_vals !== {4'h0, exp_seq[i]}) begin
        errors++; $display("FAIL cnt_step%0d got=%h exp=%h", i, bus.out_vals, {4'h0, exp_seq[i]});
      end
    end
    @(negedge clk);
    bus.en = 1'b0; #1;
    checks++;
    if (bus.out_vals !== 6'h00) begin errors++; $display("FAIL en_low got=%h exp=00", bus.out_vals); end
    @(negedge clk); @(negedge clk);
    bus.en = 1'b1; #1;
    checks++;
    if (bus.out_vals !== 6'h01) begin errors++; $display("FAIL en_frozen got=%h exp=01", bus.out_vals); end
    bus.in_vars = 8'h00;
  endtask

  task automatic test_readback();
    int bad = 0;
    for (int unsigned i = 0; i < CL; i++) begin
      @(negedge clk);
      if (bus.cfg_out !== cfg_c[i]) begin
        if (bad == 0) $display("FAIL readback bit%0d got=%b exp=%b", i, bus.cfg_out, cfg_c[i]);
        bad++;
      end
      bus.cfg_shift = 1'b1;
      bus.cfg_in    = 1'b0;
    end
    @(negedge clk);
    bus.cfg_shift = 1'b0;
    checks++;
    if (bad != 0) errors++;
    #1;
    checks++;
    if (bus.out_vals !== 6'h01) begin errors++; $display("FAIL readback_out got=%h exp=01", bus.out_vals); end
  endtask

  task automatic test_back_to_back();
    bus.in_vars = 8'h00;
    shift_bits(cfg_d, CL);
    @(negedge clk);
    bus.cfg_commit = 1'b1;
    bus.in_vars    = 8'h80; #1;
    checks++;
    if (bus.out_vals !== 6'h01) begin errors++; $display("FAIL recommit_pre got=%h exp=01", bus.out_vals); end
    @(negedge clk);
    bus.cfg_commit = 1'b0; #1;
    checks++;
    if (bus.out_vals !== 6'h04) begin errors++; $display("FAIL recommit_clear got=%h exp=04", bus.out_vals); end
    @(negedge clk); #1;
    checks++;
    if (bus.out_vals !== 6'h05) begin errors++; $display("FAIL recommit_next got=%h exp=05", bus.out_vals); end
  endtask

  initial begin
    bus.en = 1'b1; bus.cfg_in = 1'b0; bus.cfg_shift = 1'b0; bus.cfg_commit = 1'b0; bus.in_vars = 8'h00;
    cfg_a = '0;
    cfg_a[0] = 1'b1; cfg_a[3] = 1'b1; cfg_a[532] = 1'b1;
    cfg_b = cfg_a;
    cfg_b[646] = 1'b1; cfg_b[647] = 1'b1;
    cfg_c = '0;
    cfg_c[14] = 1'b1; cfg_c[42] = 1'b1; cfg_c[44] = 1'b1;
    cfg_c[532] = 1'b1; cfg_c[552] = 1'b1; cfg_c[647] = 1'b1; cfg_c[649] = 1'b1;
    cfg_d = cfg_c;
    cfg_d[70] = 1'b1; cfg_d[572] = 1'b1;
    #1;
    checks++;
    if (bus.out_vals !== 6'h00 || bus.cfg_loaded !== 1'b0 || bus.cfg_out !== 1'b0) begin
      errors++; $display("FAIL por got out=%h loaded=%b cfg_out=%b exp 00/0/0", bus.out_vals, bus.cfg_loaded, bus.cfg_out);
    end
    @(negedge clk);
    res = 1'b0;
    test_reset();
    test_comb();
    test_short_load();
    test_counter();
    test_readback();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
